// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling at a fixed divisor, single-register output.
// valid/frame_err/overrun appear the cycle after the stop sample; a full output drops the new byte and pulses overrun.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;

    logic rx_meta;
    logic rxs;
    logic rx_prev;

    logic stop_hit;
    logic good_byte;
    logic bad_stop;

    // Reset to the idle level so that reset itself never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rx_prev <= rxs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs && rx_prev) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rxs;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leave mid-stop-bit so the next start edge is not missed.
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stop_hit  = (state == STOP) && (cnt == BIT_LAST);
    assign good_byte = stop_hit && rxs;
    assign bad_stop  = stop_hit && !rxs;

    // A completing byte may replace the held one only if that one is consumed this same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= 1'b0;
            if (good_byte) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that pairs with the existing UART transmitter. It takes the asynchronous 8N1 line (`rx`), recovers each frame by mid-bit sampling at a fixed baud divisor, and presents received bytes on a valid/ready interface for the core-side consumer. The framing, divisor and LSB-first bit order match the transmitter exactly, so a loopback of `q` to `rx` reproduces the transmitted byte.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud); legal range is at least 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `data`  out  8  received byte; held stable while `valid`=1.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` in any cycle with `valid`&`ready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the output is full.

## Operation
- **Synchronizer:** two-flop synchronizer on `rx`, both flops reset to 1. A third registered copy (`rx_prev`, reset 1) supports edge detection. All logic uses the synchronized value `rxs`.
- **Counters:** bit counter `cnt` has width `$clog2(CLKS_PER_BIT)`. Half-bit `H = CLKS_PER_BIT/2` (integer division). Bit index `idx` is 3 bits.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** when `rxs`=0 and `rx_prev`=1 (falling edge), go to START with `cnt`=0. A line held low (break) never re-triggers without first returning high.
  - **START:** when `cnt` = H−1, sample `rxs`.
    - If 0, go to DATA with `cnt`=0 and `idx`=0.
    - If 1, treat as a glitch and return to IDLE with no output.
  - **DATA:** when `cnt` = `CLKS_PER_BIT`−1, sample `rxs` into shift register bit `idx` (LSB first) and reset `cnt`. After `idx`=7 is sampled, go to STOP.
  - **STOP:** when `cnt` = `CLKS_PER_BIT`−1, sample `rxs`, then go to IDLE in all cases. The FSM returns mid-stop-bit so back-to-back frames are caught.
    - If 1: good byte, delivered through the output stage.
    - If 0: pulse `frame_err`; the byte is discarded.
- **Output stage** (single register; evaluated in the cycle a good byte completes):
  - `valid`=0: load `data`, set `valid`.
  - `valid`=1 and `ready`=1: old byte is consumed and the new byte is loaded in the same cycle; `valid` stays 1.
  - `valid`=1 and `ready`=0: pulse `overrun`; keep the old byte; drop the new one.
  - With no completion, `valid`&`ready` clears `valid`.
- **Reset (any time, including mid-frame):** the FSM goes to IDLE and `cnt`, `idx` and the shift register clear. Outputs reset to `data`=0, `valid`=0, `frame_err`=0, `overrun`=0. After reset, a frame already in progress is picked up only at its next falling edge; a partial frame never produces output.

## Timing
- Synchronizer latency is 2 cycles; edge detection adds 1 more.
- Let T0 be the cycle IDLE→START occurs. Start sample is at T0+H. Data bit i is sampled at T0+H+(i+1)·`CLKS_PER_BIT`. Stop is sampled at T0+H+9·`CLKS_PER_BIT`.
- `valid` / `frame_err` / `overrun` assert on the clock edge that takes the stop sample, i.e. they are visible the cycle after it.
- Glitch rejection: a low pulse shorter than H cycles at the synchronizer output returns the FSM to IDLE.
- Consumer throughput: `ready` may be held high permanently; the interface has no combinational path from `ready` to `valid`.
- Tolerated baud mismatch is about ±4% (mid-bit sampling over 10 bits).

## Test plan
Benches run with `CLKS_PER_BIT`=16 and drive `rx` from a bit-accurate model (16 cycles per bit).
- **Single byte:** send 0xA5 with `ready`=1 → `data`=0xA5 and `valid` high for exactly 1 cycle at T0+8+144+1; `frame_err`=`overrun`=0.
- **Back-to-back frames:** send 0x00, 0xFF, 0x55 with no idle gap, `ready`=1 → three `valid` pulses with those values in order, spaced 160 cycles apart.
- **Glitch and framing error:** a 5-cycle low pulse on `rx` → no output, FSM back in IDLE. Then send 0x3C with stop bit 0 → `frame_err` pulses once; `valid` stays 0. Then send 0x3C normally → 0x3C delivered.
- **Backpressure:** `ready`=0, send 0x11 then 0x22 → `valid`=1 with `data`=0x11 and a single `overrun` pulse at the end of the 0x22 frame. Raise `ready` → `valid` drops the next cycle.
- **Consume on completion:** `valid`=1 holding 0x11, with `ready`=1 exactly in the completion cycle of 0x22 → no `overrun`; `data`=0x22 with `valid` still 1.
- **Reset mid-frame:** assert `rst` during bit 4 of 0x99, release while `rx` is still mid-frame → all outputs 0, nothing delivered for that frame. Next frame 0x42 → 0x42 delivered.
- **Loopback:** connect the transmitter `q` to `rx` with a shared divisor and send 0x00–0xFF → all 256 bytes received in order.
